// File: rtl/oddeven_checker_if.sv
`default_nettype none
// ============================================================================
//  Module      : oddeven_checker_if
//  Description : Signal bundle between a 3-bit odd/even counter stream and
//                its receive-side checker. The master side drives the sample
//                strobe and counter bits; the slave side (the checker)
//                returns lock status, mode, pulses and the error count.
//  Ports       : en, in2..in0        - strobe and counter bits (master->slave)
//                locked, odd, err,
//                wrap, err_cnt       - checker status (slave->master)
//  Revision    : 1.0  initial release
// ============================================================================
interface oddeven_checker_if #(
    parameter int ERR_W = 8
);
    logic             en;
    logic             in2;
    logic             in1;
    logic             in0;
    logic             locked;
    logic             odd;
    logic             err;
    logic             wrap;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output en, in2, in1, in0,
        input  locked, odd, err, wrap, err_cnt
    );

    modport slave (
        input  en, in2, in1, in0,
        output locked, odd, err, wrap, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/oddeven_checker.sv
`default_nettype none
// ============================================================================
//  Module      : oddeven_checker
//  Description : Receive-side monitor for a 3-bit odd/even counter stream.
//                Samples v = {in2,in1,in0} on enabled edges, infers the mode
//                from parity, locks after LOCK_N consecutive +2 (mod 8) steps,
//                and while locked flags/counts violations and reports wraps.
//  Ports       : clk            - clock, rising edge
//                rst            - synchronous active-high reset
//                bus (slave)    - en, in2..in0 in; locked, odd, err, wrap,
//                                 err_cnt[ERR_W-1:0] out (all registered)
//  Parameters  : LOCK_N (1..15) good steps to lock, ERR_W (1..16) counter width
//  Revision    : 1.0  initial release
// ============================================================================
module oddeven_checker #(
    parameter int LOCK_N = 4,
    parameter int ERR_W  = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    oddeven_checker_if.slave  bus
);

    localparam logic [3:0]       c_LOCK_N  = 4'(LOCK_N);
    localparam logic [ERR_W-1:0] c_CNT_ONE = ERR_W'(1);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        CHECK = 2'd1,
        LOCK  = 2'd2
    } state_t;

    state_t           r_state,   w_state_nxt;
    logic [2:0]       r_prev,    w_prev_nxt;
    logic [3:0]       r_good,    w_good_nxt;
    logic             r_odd,     w_odd_nxt;
    logic             r_err,     w_err_nxt;
    logic             r_wrap,    w_wrap_nxt;
    logic             r_locked,  w_locked_nxt;
    logic [ERR_W-1:0] r_err_cnt, w_err_cnt_nxt;

    logic [2:0] w_v;
    logic [2:0] w_prev_p2;
    logic [3:0] w_good_inc;
    logic       w_good_step;
    logic       w_wrap_step;

    assign w_v         = {bus.in2, bus.in1, bus.in0};
    assign w_prev_p2   = r_prev + 3'd2;          // wraps mod 8 by width
    assign w_good_inc  = r_good + 4'd1;
    assign w_good_step = (w_v == w_prev_p2);
    // Every good step leaving 6 or 7 lands on 0 or 1, i.e. a wrap.
    assign w_wrap_step = w_good_step && (r_prev[2:1] == 2'b11);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= HUNT;
            r_prev    <= 3'd0;
            r_good    <= 4'd0;
            r_odd     <= 1'b0;
            r_err     <= 1'b0;
            r_wrap    <= 1'b0;
            r_locked  <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_prev    <= w_prev_nxt;
            r_good    <= w_good_nxt;
            r_odd     <= w_odd_nxt;
            r_err     <= w_err_nxt;
            r_wrap    <= w_wrap_nxt;
            r_locked  <= w_locked_nxt;
            r_err_cnt <= w_err_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_prev_nxt    = r_prev;
        w_good_nxt    = r_good;
        w_odd_nxt     = r_odd;
        w_err_nxt     = 1'b0;
        w_wrap_nxt    = 1'b0;
        w_err_cnt_nxt = r_err_cnt;

        if (bus.en) begin
            w_prev_nxt = w_v;
            unique case (r_state)
                HUNT: begin
                    w_state_nxt = CHECK;
                    w_good_nxt  = 4'd0;
                    w_odd_nxt   = w_v[0];
                end
                CHECK: begin
                    w_odd_nxt = w_v[0];
                    if (w_good_step) begin
                        w_good_nxt = w_good_inc;
                        w_wrap_nxt = w_wrap_step;
                        if (w_good_inc == c_LOCK_N) begin
                            w_state_nxt = LOCK;
                        end
                    end else begin
                        w_good_nxt = 4'd0;
                    end
                end
                LOCK: begin
                    if (w_good_step) begin
                        // Mode only follows the stream on good steps so it
                        // holds through a violation until relock.
                        w_odd_nxt  = w_v[0];
                        w_wrap_nxt = w_wrap_step;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_good_nxt  = 4'd0;
                        w_state_nxt = CHECK;
                        if (!(&r_err_cnt)) begin
                            w_err_cnt_nxt = r_err_cnt + c_CNT_ONE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = HUNT;
                    w_good_nxt  = 4'd0;
                end
            endcase
        end

        w_locked_nxt = (w_state_nxt == LOCK);
    end

    assign bus.locked  = r_locked;
    assign bus.odd     = r_odd;
    assign bus.err     = r_err;
    assign bus.wrap    = r_wrap;
    assign bus.err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_oddeven_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_oddeven_checker
//  Description : Self-checking bench for oddeven_checker. Two instances share
//                one stimulus stream: dut_a (LOCK_N=4, ERR_W=8) and dut_b
//                (LOCK_N=1, ERR_W=2). Directed vectors with table expectations,
//                a saturation sequence, then randomized traffic, all also
//                compared every cycle against a run-length reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_oddeven_checker;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    oddeven_checker_if #(.ERR_W(8)) ifa ();
    oddeven_checker_if #(.ERR_W(2)) ifb ();

    oddeven_checker #(.LOCK_N(4), .ERR_W(8)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    oddeven_checker #(.LOCK_N(1), .ERR_W(2)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: counts consecutive good steps since arming; locked
    // whenever that run has reached the lock threshold.
    typedef struct {
        bit armed;
        int run;
        int prev;
        bit odd;
        bit err;
        bit wrap;
        int cnt;
    } model_t;

    model_t ma, mb;

    function automatic model_t mstep(model_t m, int lockn, int maxc, bit r, bit e, int v);
        model_t n;
        bit     good;
        bit     was_locked;
        n      = m;
        n.err  = 1'b0;
        n.wrap = 1'b0;
        if (r) begin
            n.armed = 1'b0; n.run = 0; n.prev = 0; n.odd = 1'b0; n.cnt = 0;
            return n;
        end
        if (!e) return n;
        if (!m.armed) begin
            n.armed = 1'b1;
            n.run   = 0;
            n.odd   = bit'(v % 2);
        end else begin
            good       = (v == (m.prev + 2) % 8);
            was_locked = (m.run >= lockn);
            if (good) begin
                n.run  = m.run + 1;
                n.odd  = bit'(v % 2);
                n.wrap = (m.prev >= 6);
            end else begin
                n.run = 0;
                if (was_locked) begin
                    n.err = 1'b1;
                    n.cnt = (m.cnt < maxc) ? m.cnt + 1 : maxc;
                end else begin
                    n.odd = bit'(v % 2);
                end
            end
        end
        n.prev = v;
        return n;
    endfunction

    function automatic bit mlocked(model_t m, int lockn);
        return m.armed && (m.run >= lockn);
    endfunction

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_models();
        chk("a.locked", int'(ifa.locked), int'(mlocked(ma, 4)));
        chk("a.odd",    int'(ifa.odd),    int'(ma.odd));
        chk("a.err",    int'(ifa.err),    int'(ma.err));
        chk("a.wrap",   int'(ifa.wrap),   int'(ma.wrap));
        chk("a.cnt",    int'(ifa.err_cnt), ma.cnt);
        chk("b.locked", int'(ifb.locked), int'(mlocked(mb, 1)));
        chk("b.odd",    int'(ifb.odd),    int'(mb.odd));
        chk("b.err",    int'(ifb.err),    int'(mb.err));
        chk("b.wrap",   int'(ifb.wrap),   int'(mb.wrap));
        chk("b.cnt",    int'(ifb.err_cnt), mb.cnt);
    endtask

    // One clock: drive at negedge, sample 1 time unit after the rising edge.
    task automatic tick(bit r, bit e, int v);
        logic [2:0] vb;
        vb = 3'(v);
        @(negedge clk);
        rst = r;
        ifa.en = e; ifa.in2 = vb[2]; ifa.in1 = vb[1]; ifa.in0 = vb[0];
        ifb.en = e; ifb.in2 = vb[2]; ifb.in1 = vb[1]; ifb.in0 = vb[0];
        @(posedge clk);
        #1;
        ma = mstep(ma, 4, 255, r, e, v);
        mb = mstep(mb, 1, 3, r, e, v);
        cmp_models();
    endtask

    typedef struct {
        bit rst;
        bit en;
        int v;
        bit locked;
        bit odd;
        bit err;
        bit wrap;
        int cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit r, bit e, int v, bit l, bit o, bit er, bit w, int c);
        vec_t x;
        x.rst = r; x.en = e; x.v = v; x.locked = l; x.odd = o;
        x.err = er; x.wrap = w; x.cnt = c;
        tbl.push_back(x);
    endfunction

    initial begin
        int pulses;
        int v;
        int cur;

        ma = '{default: 0};
        mb = '{default: 0};
        rst = 1'b0;
        ifa.en = 1'b0; ifa.in2 = 1'b0; ifa.in1 = 1'b0; ifa.in0 = 1'b0;
        ifb.en = 1'b0; ifb.in2 = 1'b0; ifb.in1 = 1'b0; ifb.in0 = 1'b0;

        // Expectations below are for dut_a (LOCK_N=4, ERR_W=8).
        //   rst en v  lk od er wr cnt
        // Odd lock, wrap 7->1, then parity violation and even relock.
        add(1, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 1, 0, 0, 0);
        add(0, 1, 3, 0, 1, 0, 0, 0);
        add(0, 1, 5, 0, 1, 0, 0, 0);
        add(0, 1, 7, 0, 1, 0, 0, 0);
        add(0, 1, 1, 1, 1, 0, 1, 0);
        add(0, 1, 3, 1, 1, 0, 0, 0);
        add(0, 1, 5, 1, 1, 0, 0, 0);
        add(0, 1, 4, 0, 1, 1, 0, 1);
        add(0, 1, 6, 0, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0, 1, 1);
        add(0, 1, 2, 0, 0, 0, 0, 1);
        add(0, 1, 4, 1, 0, 0, 0, 1);
        // Even lock with wrap on the locking sample.
        add(1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 2, 0, 0, 0, 0, 0);
        add(0, 1, 4, 0, 0, 0, 0, 0);
        add(0, 1, 6, 0, 0, 0, 0, 0);
        add(0, 1, 0, 1, 0, 0, 1, 0);
        // EN=0 holds everything while locked.
        add(1, 1, 5, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 1, 0, 0, 0);
        add(0, 1, 3, 0, 1, 0, 0, 0);
        add(0, 1, 5, 0, 1, 0, 0, 0);
        add(0, 1, 7, 0, 1, 0, 0, 0);
        add(0, 1, 1, 1, 1, 0, 1, 0);
        add(0, 1, 3, 1, 1, 0, 0, 0);
        add(0, 1, 5, 1, 1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0, 0);
        add(0, 1, 7, 1, 1, 0, 0, 0);
        add(0, 1, 1, 1, 1, 0, 1, 0);
        // Two violations, then reset mid-stream; next sample must not error.
        add(0, 1, 4, 0, 1, 1, 0, 1);
        add(0, 1, 6, 0, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0, 1, 1);
        add(0, 1, 2, 0, 0, 0, 0, 1);
        add(0, 1, 4, 1, 0, 0, 0, 1);
        add(0, 1, 4, 0, 0, 1, 0, 2);
        add(1, 1, 3, 0, 0, 0, 0, 0);
        add(0, 1, 3, 0, 1, 0, 0, 0);
        add(0, 1, 5, 0, 1, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            tick(tbl[i].rst, tbl[i].en, tbl[i].v);
            chk($sformatf("tbl[%0d].locked", i), int'(ifa.locked), int'(tbl[i].locked));
            chk($sformatf("tbl[%0d].odd", i),    int'(ifa.odd),    int'(tbl[i].odd));
            chk($sformatf("tbl[%0d].err", i),    int'(ifa.err),    int'(tbl[i].err));
            chk($sformatf("tbl[%0d].wrap", i),   int'(ifa.wrap),   int'(tbl[i].wrap));
            chk($sformatf("tbl[%0d].cnt", i),    int'(ifa.err_cnt), tbl[i].cnt);
        end

        // Saturation on dut_b (LOCK_N=1, ERR_W=2): stall, relock, repeat.
        tick(1, 0, 0);
        tick(0, 1, 1);
        tick(0, 1, 3);
        chk("sat.initial_lock", int'(ifb.locked), 1);
        cur    = 3;
        pulses = 0;
        for (int k = 1; k <= 5; k++) begin
            tick(0, 1, cur);                       // stall is a bad step
            if (ifb.err) pulses++;
            chk($sformatf("sat[%0d].cnt", k), int'(ifb.err_cnt), (k < 3) ? k : 3);
            chk($sformatf("sat[%0d].locked_drop", k), int'(ifb.locked), 0);
            cur = (cur + 2) % 8;
            tick(0, 1, cur);                       // one good step relocks
            if (ifb.err) pulses++;
            chk($sformatf("sat[%0d].relock", k), int'(ifb.locked), 1);
        end
        chk("sat.err_pulses", pulses, 5);

        // Randomized traffic, mostly legal steps with occasional faults.
        tick(1, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) < 8) v = (ma.prev + 2) % 8;
            else                          v = int'($urandom_range(0, 7));
            tick(($urandom_range(0, 249) == 0), ($urandom_range(0, 3) != 0), v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/oddeven_checker.md
# oddeven_checker

Receive-side monitor for the 3-bit odd/even counter stream. It samples the counter bits each enabled cycle, infers the counting mode from parity, and locks onto the sequence after a run of consistent steps. While locked it flags and counts sequence violations and reports wrap-arounds. It sits downstream of the counter in the exercise designs, as a self-check on the counter's outputs.

## Interface
- LOCK_N, default 4: consecutive good steps needed to lock; legal range 1..15.
- ERR_W, default 8: width of the error counter; legal range 1..16.

- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- EN  input  1  sample strobe; IN2..IN0 are sampled only on edges where EN=1.
- IN2, IN1, IN0  input  1 each  counter bits, with IN2 as the MSB; v = {IN2,IN1,IN0}.
- LOCKED  output  1  high while the state is LOCK.
- ODD  output  1  mode of the tracked sequence; 1 means odd (1,3,5,7), 0 means even (0,2,4,6).
- ERR  output  1  one-cycle pulse on a sequence violation while locked.
- WRAP  output  1  one-cycle pulse on a good 7→1 or 6→0 step.
- ERR_CNT  output  ERR_W  saturating count of ERR pulses.

## Operation
- Internal registers:
  - prev[2:0]: the last accepted sample.
  - good: a run counter of 4 bits.
  - State is one of HUNT, CHECK, LOCK.
- Good step: v == (prev + 2) mod 8. This implies the parity is unchanged. The legal steps are 1→3→5→7→1 and 0→2→4→6→0.
- Bad step: any other v, including v == prev (stall) and any parity change.
- An edge with EN=0 changes nothing: state, prev, good, ODD, LOCKED and ERR_CNT hold, and ERR=WRAP=0.
- Every enabled sample loads prev := v.
- ODD is updated to v[0] in HUNT and CHECK. In LOCK it is updated only on a good step, so it holds through errors until relock.
- HUNT: on an enabled edge, go to CHECK with good := 0.
- CHECK:
  - Good step: good := good+1. If good+1 == LOCK_N, go to LOCK.
  - Bad step: good := 0 and stay in CHECK. No ERR pulse is produced.
- LOCK:
  - Good step: stay in LOCK.
  - Bad step: pulse ERR, do ERR_CNT := ERR_CNT+1 (saturating at all-ones), good := 0, and go to CHECK. The bad sample becomes the new prev.
- WRAP pulses on any good step from 7 to 1 or from 6 to 0, in CHECK or in LOCK. It never pulses on a bad step.
- ERR_CNT is cleared only by RST. It does not change on relock.
- LOCKED is the registered decode of state == LOCK.

## Timing
- All outputs are registered. A sample taken at edge t is reflected in the outputs immediately after edge t, so the latency is one edge from input to output.
- Reset, at the first edge with RST=1, sets:
  - state = HUNT, prev = 0, good = 0
  - LOCKED = 0, ODD = 0, ERR = 0, WRAP = 0, ERR_CNT = 0
- RST has priority over EN. Reset in the middle of a lock drops LOCKED at that same edge.
- Lock timing: the first enabled sample s0 arms CHECK. LOCKED rises after the edge that samples s_LOCK_N. That is LOCK_N+1 enabled samples from HUNT.
- On the edge that detects a violation: ERR=1, LOCKED falls to 0, and ERR_CNT increments. All three are visible after that same edge.
- ERR and WRAP are never high together. Each is high for exactly one cycle, even if EN stays high.
- Relock after an error needs LOCK_N further good steps counted from the bad sample.
- LOCK_N=1: lock after the first good step following HUNT.

## Test plan
- Reset, then EN=1 with v = 1,3,5,7,1,3 (LOCK_N=4):
  - LOCKED=1 after the 5th sample, with ODD=1.
  - WRAP pulses at the 7→1 step.
  - ERR stays 0.
- Reset, then v = 0,2,4,6,0:
  - LOCKED=1 after the 5th sample, with ODD=0.
  - WRAP=1 on the 6→0 sample.
- While locked in odd mode, feed 5 then 4 (parity change):
  - ERR=1 for one cycle, ERR_CNT=1, LOCKED=0.
  - Continuing 6,0,2,4 relocks with ODD=0.
- With ERR_W=2, force 5 violations, each followed by relocking:
  - ERR_CNT goes 1,2,3,3,3, saturating at 3.
  - ERR pulses 5 times.
- Locked on 1,3,5, then EN=0 for 3 cycles while v=0:
  - No change: prev stays 5 and LOCKED stays 1.
  - EN=1 with v=7 gives a good step with no ERR.
- Locked with ERR_CNT=2, assert RST for one edge:
  - All outputs go to 0 and the state returns to HUNT.
  - The next sample v=3 does not produce ERR.
